// File: rtl/sram_bist_pkg.sv
// Shared types and per-element constant tables for the March C- BIST sequencer.
// Bit n of each table describes march element Mn.
package sram_bist_pkg;

    typedef enum logic [2:0] {
        M0 = 3'd0,
        M1 = 3'd1,
        M2 = 3'd2,
        M3 = 3'd3,
        M4 = 3'd4,
        M5 = 3'd5
    } elem_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int FAIL_COUNT_WIDTH = 16;

    // Direction: 1 = descending address order.
    localparam logic [5:0] ELEM_DESCENDING = 6'b111000;
    // Op count: 1 = read-then-write pair, 0 = single op.
    localparam logic [5:0] ELEM_TWO_OPS    = 6'b011110;
    // 1 = the element's first op is a read.
    localparam logic [5:0] ELEM_FIRST_READ = 6'b111110;
    // Pattern selects: 1 = D1 (inverted background), 0 = D0.
    localparam logic [5:0] ELEM_READ_D1    = 6'b010100;
    localparam logic [5:0] ELEM_WRITE_D1   = 6'b001010;

endpackage

// File: rtl/sram_bist_cmp.sv
// Read-compare stage: registers the expected word for each issued read and
// compares it with sram_dout a cycle later. First-failure log under SRAM_BIST_FAIL_LOG_EN.
module sram_bist_cmp
    import sram_bist_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 9
) (
    input  logic                        clk,
    input  logic                        rstb,
    input  logic                        clear,
    input  logic                        rd_valid,
    input  logic [ADDR_WIDTH-1:0]       rd_addr,
    input  elem_t                       rd_elem,
    input  logic [DATA_WIDTH-1:0]       rd_exp,
    input  logic [DATA_WIDTH-1:0]       sram_dout,
    output logic                        ok,
    output logic [FAIL_COUNT_WIDTH-1:0] fail_count,
    output logic [ADDR_WIDTH-1:0]       fail_addr,
    output logic [2:0]                  fail_elem,
    output logic [DATA_WIDTH-1:0]       fail_data
);

    logic                  exp_valid;
    logic [DATA_WIDTH-1:0] exp_data;
    logic                  ok_reg;
    logic                  miscompare;

    assign miscompare = exp_valid && (sram_dout != exp_data);
    // Includes the compare happening this cycle so the final read counts on DONE entry.
    assign ok = ok_reg && !miscompare;

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            exp_valid <= 1'b0;
            exp_data  <= '0;
            ok_reg    <= 1'b1;
        end else if (clear) begin
            exp_valid <= 1'b0;
            exp_data  <= '0;
            ok_reg    <= 1'b1;
        end else begin
            exp_valid <= rd_valid;
            exp_data  <= rd_exp;
            if (miscompare) ok_reg <= 1'b0;
        end
    end

`ifdef SRAM_BIST_FAIL_LOG_EN
    logic [ADDR_WIDTH-1:0] exp_addr;
    elem_t                 exp_elem;

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            exp_addr   <= '0;
            exp_elem   <= M0;
            fail_count <= '0;
            fail_addr  <= '0;
            fail_elem  <= '0;
            fail_data  <= '0;
        end else if (clear) begin
            exp_addr   <= '0;
            exp_elem   <= M0;
            fail_count <= '0;
            fail_addr  <= '0;
            fail_elem  <= '0;
            fail_data  <= '0;
        end else begin
            exp_addr <= rd_addr;
            exp_elem <= rd_elem;
            if (miscompare) begin
                if (fail_count != '1) fail_count <= fail_count + FAIL_COUNT_WIDTH'(1);
                // A zero count means nothing captured yet; the count never wraps back.
                if (fail_count == '0) begin
                    fail_addr <= exp_addr;
                    fail_elem <= exp_elem;
                    fail_data <= sram_dout;
                end
            end
        end
    end
`else
    logic unused_log;
    assign unused_log = ^{rd_addr, rd_elem};
    assign fail_count = '0;
    assign fail_addr  = '0;
    assign fail_elem  = '0;
    assign fail_data  = '0;
`endif

endmodule

// File: rtl/sram_march_bist.sv
// March C- BIST sequencer driving an sram22 macro; optional first-failure log
// enabled by defining SRAM_BIST_FAIL_LOG_EN.
module sram_march_bist
    import sram_bist_pkg::*;
#(
    parameter int                    DATA_WIDTH  = 32,
    parameter int                    ADDR_WIDTH  = 9,
    parameter int                    WMASK_WIDTH = 1,
    parameter logic [DATA_WIDTH-1:0] BACKGROUND  = '0
) (
    input  logic                        clk,
    input  logic                        rstb,
    input  logic                        start,
    output logic                        busy,
    output logic                        done,
    output logic                        pass,
    output logic                        sram_we,
    output logic [WMASK_WIDTH-1:0]      sram_wmask,
    output logic [ADDR_WIDTH-1:0]       sram_addr,
    output logic [DATA_WIDTH-1:0]       sram_din,
    input  logic [DATA_WIDTH-1:0]       sram_dout,
    input  logic                        sram_sae_int,
    output logic                        sram_sae_muxed,
    output logic [FAIL_COUNT_WIDTH-1:0] fail_count,
    output logic [ADDR_WIDTH-1:0]       fail_addr,
    output logic [2:0]                  fail_elem,
    output logic [DATA_WIDTH-1:0]       fail_data
);

    state_t                state, state_next;
    elem_t                 elem, src_elem, nxt_elem, bus_elem;
    logic [ADDR_WIDTH-1:0] addr_cnt, src_addr, nxt_addr;
    logic                  phase, src_phase, nxt_phase;
    logic                  seq_end, nxt_end;
    logic                  issue, restart, op_rd, last_addr, elem_last_op;
    logic                  bus_rd, cmp_ok;
    logic [DATA_WIDTH-1:0] wr_pat, rd_exp;

    assign busy           = (state == RUN) || (state == DRAIN);
    assign done           = (state == DONE);
    assign sram_sae_muxed = sram_sae_int;

    // The counters hold the next op; a restart issues op 0 directly so it hits the bus one cycle after start.
    always_comb begin
        // NOTE: every comb output gets a default first so no path can infer a latch.
        state_next = state;
        src_elem   = elem;
        src_addr   = addr_cnt;
        src_phase  = phase;
        issue      = 1'b0;
        restart    = 1'b0;
        case (state)
            IDLE, DONE: if (start) begin
                state_next = RUN;
                restart    = 1'b1;
                issue      = 1'b1;
                src_elem   = M0;
                src_addr   = '0;
                src_phase  = 1'b0;
            end
            RUN: begin
                if (seq_end) state_next = DRAIN;
                else         issue      = 1'b1;
            end
            DRAIN:   state_next = DONE;
            default: state_next = IDLE;
        endcase

        op_rd  = ELEM_FIRST_READ[src_elem] && !src_phase;
        wr_pat = ELEM_WRITE_D1[src_elem] ? ~BACKGROUND : BACKGROUND;
        rd_exp = ELEM_READ_D1[bus_elem] ? ~BACKGROUND : BACKGROUND;

        last_addr    = ELEM_DESCENDING[src_elem] ? (src_addr == '0) : (src_addr == '1);
        elem_last_op = !ELEM_TWO_OPS[src_elem] || src_phase;
        nxt_phase    = ELEM_TWO_OPS[src_elem] && !src_phase;
        nxt_elem     = src_elem;
        nxt_addr     = src_addr;
        nxt_end      = 1'b0;
        if (elem_last_op) begin
            if (last_addr) begin
                if (src_elem == M5) begin
                    nxt_end = 1'b1;
                end else begin
                    nxt_elem = elem_t'(src_elem + 3'd1);
                    nxt_addr = ELEM_DESCENDING[nxt_elem] ? '1 : '0;
                end
            end else begin
                nxt_addr = ELEM_DESCENDING[src_elem] ? src_addr - ADDR_WIDTH'(1)
                                                     : src_addr + ADDR_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state      <= IDLE;
            elem       <= M0;
            addr_cnt   <= '0;
            phase      <= 1'b0;
            seq_end    <= 1'b0;
            bus_rd     <= 1'b0;
            bus_elem   <= M0;
            sram_we    <= 1'b0;
            sram_wmask <= '0;
            sram_addr  <= '0;
            sram_din   <= '0;
            pass       <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state <= state_next;
            if (issue) begin
                elem       <= nxt_elem;
                addr_cnt   <= nxt_addr;
                phase      <= nxt_phase;
                seq_end    <= nxt_end;
                bus_rd     <= op_rd;
                bus_elem   <= src_elem;
                sram_we    <= !op_rd;
                sram_wmask <= op_rd ? '0 : '1;
                sram_addr  <= src_addr;
                sram_din   <= op_rd ? '0 : wr_pat;
            end else begin
                bus_rd     <= 1'b0;
                sram_we    <= 1'b0;
                sram_wmask <= '0;
                sram_addr  <= '0;
                sram_din   <= '0;
            end
            if (restart)               pass <= 1'b0;
            else if (state == DRAIN)   pass <= cmp_ok;
        end
    end

    sram_bist_cmp #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_cmp (
        .clk        (clk),
        .rstb       (rstb),
        .clear      (restart),
        .rd_valid   (bus_rd),
        .rd_addr    (sram_addr),
        .rd_elem    (bus_elem),
        .rd_exp     (rd_exp),
        .sram_dout  (sram_dout),
        .ok         (cmp_ok),
        .fail_count (fail_count),
        .fail_addr  (fail_addr),
        .fail_elem  (fail_elem),
        .fail_data  (fail_data)
    );

endmodule

// File: tb/tb_sram_march_bist.sv
// Scoreboard bench for sram_march_bist with a behavioural SRAM and an optional
// stuck-at-0 cell (bit 3 of address 5).
module tb_sram_march_bist;

    localparam int DW    = 32;
    localparam int AW    = 9;
    localparam int DEPTH = 512;
    localparam int NOPS  = 10 * DEPTH;
    localparam logic [DW-1:0] D0 = 32'h0000_0000;
    localparam logic [DW-1:0] D1 = 32'hFFFF_FFFF;

    typedef struct packed {
        logic          we;
        logic          wmask;
        logic [AW-1:0] addr;
        logic [DW-1:0] din;
    } op_t;

    typedef struct packed {
        logic          pass;
        logic [15:0]   cnt;
        logic [AW-1:0] addr;
        logic [2:0]    elem;
        logic [DW-1:0] data;
        logic [15:0]   busy_cycles;
    } res_t;

    logic          clk, rstb, start;
    logic          busy, done, pass;
    logic          sram_we;
    logic [0:0]    sram_wmask;
    logic [AW-1:0] sram_addr;
    logic [DW-1:0] sram_din, sram_dout;
    logic          sram_sae_int, sram_sae_muxed;
    logic [15:0]   fail_count;
    logic [AW-1:0] fail_addr;
    logic [2:0]    fail_elem;
    logic [DW-1:0] fail_data;

    int n_checks = 0;
    int n_bad    = 0;

    op_t   ops_q[$];
    res_t  res_q[$];
    string res_name_q[$];

    bit fault_on     = 1'b0;
    bit count_writes = 1'b0;
    int writes_after = 0;

    sram_march_bist #(
        .DATA_WIDTH  (DW),
        .ADDR_WIDTH  (AW),
        .WMASK_WIDTH (1),
        .BACKGROUND  (D0)
    ) dut (
        .clk            (clk),
        .rstb           (rstb),
        .start          (start),
        .busy           (busy),
        .done           (done),
        .pass           (pass),
        .sram_we        (sram_we),
        .sram_wmask     (sram_wmask),
        .sram_addr      (sram_addr),
        .sram_din       (sram_din),
        .sram_dout      (sram_dout),
        .sram_sae_int   (sram_sae_int),
        .sram_sae_muxed (sram_sae_muxed),
        .fail_count     (fail_count),
        .fail_addr      (fail_addr),
        .fail_elem      (fail_elem),
        .fail_data      (fail_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural SRAM: registered read, optional stuck-at-0 cell.
    logic [DW-1:0] mem [DEPTH];
    initial begin
        for (int i = 0; i < DEPTH; i++) mem[i] = '0;
        sram_dout = '0;
    end
    always @(posedge clk) begin
        if (sram_we && sram_wmask[0])
            mem[sram_addr] <= (fault_on && sram_addr == 9'd5) ? (sram_din & ~32'h8) : sram_din;
        else if (!sram_we)
            sram_dout <= mem[sram_addr];
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic push_op(input bit is_wr, input int a, input logic [DW-1:0] d);
        op_t o;
        o.we    = is_wr;
        o.wmask = is_wr;
        o.addr  = AW'(a);
        o.din   = is_wr ? d : '0;
        ops_q.push_back(o);
    endtask

    // Reference March C- sequence, built element by element.
    task automatic push_march();
        for (int e = 0; e < 6; e++) begin
            for (int i = 0; i < DEPTH; i++) begin
                int a;
                a = (e >= 3) ? (DEPTH - 1 - i) : i;
                case (e)
                    0: push_op(1'b1, a, D0);
                    1: begin push_op(1'b0, a, '0); push_op(1'b1, a, D1); end
                    2: begin push_op(1'b0, a, '0); push_op(1'b1, a, D0); end
                    3: begin push_op(1'b0, a, '0); push_op(1'b1, a, D1); end
                    4: begin push_op(1'b0, a, '0); push_op(1'b1, a, D0); end
                    default: push_op(1'b0, a, '0);
                endcase
            end
        end
    endtask

    task automatic push_res(input string name, input bit p, input logic [15:0] c,
                            input logic [AW-1:0] a, input logic [2:0] e, input logic [DW-1:0] d);
        res_t r;
        r.pass = p; r.cnt = c; r.addr = a; r.elem = e; r.data = d;
        r.busy_cycles = 16'(NOPS + 1);
        res_q.push_back(r);
        res_name_q.push_back(name);
    endtask

    // Monitor: bus ops during the op phase, run results on each rising done.
    int   ops_seen = 0;
    int   busy_cnt = 0;
    logic done_q   = 1'b0;
    always @(negedge clk) begin
        if (!rstb) begin
            ops_seen = 0;
            busy_cnt = 0;
            done_q   = 1'b0;
        end else begin
            if (count_writes && sram_we) writes_after++;
            if (busy) begin
                busy_cnt++;
                if (ops_seen < NOPS && ops_q.size() != 0) begin
                    op_t exp_op;
                    exp_op = ops_q.pop_front();
                    check($sformatf("op%0d", ops_seen + 1),
                          64'({sram_we, sram_wmask, sram_addr, sram_din}), 64'(exp_op));
                    ops_seen++;
                end
            end
            if (done && !done_q && res_q.size() != 0) begin
                res_t  r;
                string nm;
                r  = res_q.pop_front();
                nm = res_name_q.pop_front();
                check({nm, "_pass"},       64'(pass),       64'(r.pass));
                check({nm, "_fail_count"}, 64'(fail_count), 64'(r.cnt));
                check({nm, "_fail_addr"},  64'(fail_addr),  64'(r.addr));
                check({nm, "_fail_elem"},  64'(fail_elem),  64'(r.elem));
                check({nm, "_fail_data"},  64'(fail_data),  64'(r.data));
                check({nm, "_busy_len"},   64'(busy_cnt),   64'(r.busy_cycles));
                busy_cnt = 0;
                ops_seen = 0;
            end
            done_q = done;
        end
    end

    task automatic wait_done(input string name);
        int n = 0;
        while (!done && n < NOPS + 100) begin
            @(negedge clk);
            n++;
        end
        check({name, "_done_seen"}, 64'(done), 64'(1));
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"},       64'(busy),       64'(0));
        check({tag, "_done"},       64'(done),       64'(0));
        check({tag, "_pass"},       64'(pass),       64'(0));
        check({tag, "_we"},         64'(sram_we),    64'(0));
        check({tag, "_wmask"},      64'(sram_wmask), 64'(0));
        check({tag, "_addr"},       64'(sram_addr),  64'(0));
        check({tag, "_din"},        64'(sram_din),   64'(0));
        check({tag, "_fail_count"}, 64'(fail_count), 64'(0));
        check({tag, "_fail_addr"},  64'(fail_addr),  64'(0));
        check({tag, "_fail_elem"},  64'(fail_elem),  64'(0));
        check({tag, "_fail_data"},  64'(fail_data),  64'(0));
    endtask

    initial begin
        rstb = 1'b0;
        start = 1'b0;
        sram_sae_int = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        sram_sae_int = 1'b1;
        #1 check("sae_high", 64'(sram_sae_muxed), 64'(1));
        sram_sae_int = 1'b0;
        #1 check("sae_low", 64'(sram_sae_muxed), 64'(0));
        @(negedge clk) rstb = 1'b1;

        // Run A: fault-free, single start pulse.
        push_march();
        push_res("run_a", 1'b1, 16'd0, '0, 3'd0, '0);
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        wait_done("run_a");

        // Run B: stuck-at-0 cell with start held high; run C follows automatically.
        @(negedge clk);
        fault_on = 1'b1;
        push_march();
`ifdef SRAM_BIST_FAIL_LOG_EN
        push_res("run_b", 1'b0, 16'd2, 9'd5, 3'd2, 32'hFFFF_FFF7);
`else
        push_res("run_b", 1'b0, 16'd0, '0, 3'd0, '0);
`endif
        push_march();
        push_res("run_c", 1'b1, 16'd0, '0, 3'd0, '0);
        start = 1'b1;
        @(negedge clk);
        check("b_busy_start", 64'(busy), 64'(1));
        check("b_pass_cleared", 64'(pass), 64'(0));
        wait_done("run_b");
        fault_on = 1'b0;
        @(negedge clk);
        check("c_busy_restart", 64'(busy), 64'(1));
        check("c_done_low", 64'(done), 64'(0));
        check("c_pass_cleared", 64'(pass), 64'(0));
        check("c_fail_count_cleared", 64'(fail_count), 64'(0));
        start = 1'b0;
        wait_done("run_c");

        // Run D: reset asserted mid-run.
        @(negedge clk);
        push_march();
        start = 1'b1;
        @(negedge clk) start = 1'b0;
        repeat (999) @(posedge clk);
        #2;
        rstb = 1'b0;
        ops_q.delete();
        #1;
        check_all_zero("midrun_reset");
        count_writes = 1'b1;
        repeat (3) @(negedge clk);
        rstb = 1'b1;
        repeat (30) @(negedge clk);
        check("post_reset_writes", 64'(writes_after), 64'(0));
        check("post_reset_busy", 64'(busy), 64'(0));
        check("post_reset_done", 64'(done), 64'(0));

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/sram_march_bist.md
# sram_march_bist

March C- built-in self-test sequencer that sits directly upstream of an sram22 macro and owns its `clk`/`we`/`wmask`/`addr`/`din` pins while a test runs. It walks all addresses through six march elements and compares each read result one cycle after issue. It then reports pass/fail and, optionally, a first-failure log. Its outputs connect straight to the macro pins, so SRAM timing is the macro's own one-cycle registered read.

## Interface
- `DATA_WIDTH`, 32, SRAM word width
- `ADDR_WIDTH`, 9, SRAM address width; depth = 2^ADDR_WIDTH
- `WMASK_WIDTH`, 1, write-mask width; all mask bits are driven high on writes
- `BACKGROUND`, 0 (DATA_WIDTH bits), data pattern D0; D1 = ~BACKGROUND
- `clk`  in  1  sole clock, same clock as the SRAM
- `rstb`  in  1  asynchronous, active-low reset
- `start`  in  1  level; sampled only in IDLE or DONE
- `busy`  out  1  high in RUN and DRAIN
- `done`  out  1  high in DONE
- `pass`  out  1  valid when `done`; 1 = no miscompare
- `sram_we`  out  1  SRAM write enable
- `sram_wmask`  out  WMASK_WIDTH  all-ones on write, 0 otherwise
- `sram_addr`  out  ADDR_WIDTH  SRAM address
- `sram_din`  out  DATA_WIDTH  SRAM write data
- `sram_dout`  in  DATA_WIDTH  SRAM read data, valid the cycle after a read
- `sram_sae_int`  in  1  macro internal sense-amp enable
- `sram_sae_muxed`  out  1  equals `sram_sae_int` combinationally
- `fail_count`  out  16  saturating miscompare count (see Configuration)
- `fail_addr`  out  ADDR_WIDTH  address of first miscompare
- `fail_elem`  out  3  march element of first miscompare
- `fail_data`  out  DATA_WIDTH  read data of first miscompare

## Operation
- Reset values: state IDLE; `busy` = `done` = `pass` = 0; `sram_we`, `sram_wmask`, `sram_addr`, `sram_din` = 0; all `fail_*` = 0.
- States and transitions:
  - IDLE → RUN on `start`.
  - RUN → DRAIN after the last op.
  - DRAIN → DONE after 1 cycle.
  - DONE → RUN on `start`. Restarting clears `pass`, `fail_*` and the counters.
  - `start` has no effect in RUN or DRAIN.
- March C- elements, one op per cycle:
  - M0: ascending, w D0.
  - M1: ascending, r D0 then w D1.
  - M2: ascending, r D1 then w D0.
  - M3: descending, r D0 then w D1.
  - M4: descending, r D1 then w D0.
  - M5: descending, r D0.
- Two-op elements issue r and w at the same address in consecutive cycles, then advance the address.
- Ascending addresses run 0..DEPTH-1; descending run DEPTH-1..0. The address counter wraps with no extra cycle between elements.
- Reads drive `sram_we` = 0 and `sram_din` = 0. Writes drive `sram_we` = 1, `sram_wmask` = all-ones and `sram_din` = the pattern.
- Compare pipeline:
  - A read in cycle N registers the expected pattern, address and element.
  - In cycle N+1, `sram_dout` is compared to the expected pattern; any bit mismatch is a miscompare and clears the internal pass flag.
  - The final M5 read is compared during DRAIN.
- `pass` is registered on entry to DONE and held until the next start.

## Timing
- Total ops = 10 × DEPTH. With DEPTH = 512 that is 5120 RUN cycles.
- `start` is sampled at edge E. The first op is on the bus in the cycle after E.
- DRAIN is cycle 10·DEPTH + 1 after E. `done` = 1 from cycle 10·DEPTH + 2 after E.
- `busy` is high for exactly 10·DEPTH + 1 cycles per run.
- All SRAM-side outputs are registered; only `sram_sae_muxed` is combinational.
- Asserting `rstb` mid-run returns to IDLE immediately, with all outputs at reset values and no further writes issued.

## Configuration
- `SRAM_BIST_FAIL_LOG_EN` defined:
  - `fail_count` increments on each miscompare and saturates at 0xFFFF.
  - `fail_addr`, `fail_elem` and `fail_data` capture the first miscompare only and hold until restart.
- Undefined: all `fail_*` outputs are tied to 0 and no capture registers exist. `pass` behaviour is unchanged.

## Structure
- Package `sram_bist_pkg` holds:
  - the element enum M0..M5 (3 bits) and the state enum IDLE/RUN/DRAIN/DONE;
  - per-element constant tables for direction, op count, read pattern and write pattern;
  - the width of `fail_count`.
- One sub-module, `sram_bist_cmp`: the registered expected-data stage, the comparator and the fail-log registers, with capture logic under the macro.
- Address and element sequencing stay in `sram_march_bist`.

## Test plan
- Fault-free SRAM model, DEPTH = 512:
  - `start` pulse → `busy` for 5121 cycles, then `done` = 1 and `pass` = 1.
  - `fail_count` = 0.
- Bus check, same run:
  - The first 512 ops are writes with `sram_din` = 0 at addresses 0..511.
  - The op at cycle 513 after start is a read of address 0.
  - The M3 ops begin at address 511.
- Stuck-at-0 on bit 3 of address 5, log enabled:
  - `pass` = 0 and `fail_count` = 2.
  - `fail_addr` = 5, `fail_elem` = 2, `fail_data` = 0xFFFFFFF7.
- Same fault with log disabled → `pass` = 0; all `fail_*` outputs = 0.
- `rstb` low at cycle 1000 of a run → all outputs return to 0 immediately; no SRAM write after release.
- `start` held high through a run → no restart while busy. After `done`, the next sampled `start` begins a new run with `pass` and the counters cleared.
